regfile_mp: RTL and testbench

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next-generation architectural register file for the pipelined core. It provides NRD combinational read ports, NWR synchronous write ports, a hardwired-zero register 0, and per-register busy tracking for issue-stage hazard checks. Decode reads it and issues allocations into it; writeback writes into it.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 65 ++++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared constants and width helpers for the regfile_mp slice
// Rev 1.0
// ============================================================================
package regfile_pkg;

    localparam int unsigned c_XLEN_DEF = 32;
    localparam int unsigned c_NREG_DEF = 32;
    localparam int unsigned c_ZERO_REG = 0;

    function automatic int unsigned addr_w(input int unsigned nreg);
        return $clog2(nreg);
    endfunction

    // Wide enough to hold a count of NREG busy registers
    function automatic int unsigned cnt_w(input int unsigned nreg);
        return $clog2(nreg + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : busy-bit vector with flush > clear < set priority
// Rev 1.0
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = c_NREG_DEF,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = addr_w(NREG),
    localparam int unsigned CW  = cnt_w(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic              flush_i,
    output logic [NREG-1:0]   busy_o,
    output logic [CW-1:0]     busy_count_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j]) begin
                    busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
                end
            end
            // A same-cycle alloc is the younger producer, so it beats the clear
            if (alloc_en_i) begin
                busy_d[alloc_addr_i] = 1'b1;
            end
        end
        busy_d[c_ZERO_REG] = 1'b0;

        count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file with zero register and busy scoreboard
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN. Rev 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = c_XLEN_DEF,
    parameter int unsigned NREG = c_NREG_DEF,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = addr_w(NREG),
    localparam int unsigned CW  = cnt_w(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                alloc_en_i,
    input  logic [AW-1:0]       alloc_addr_i,
    input  logic                flush_i,
    output logic [CW-1:0]       busy_count_o
);

    localparam logic [AW-1:0] c_ZERO_ADDR = AW'(c_ZERO_REG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] w_busy;

    // Ascending port order lets the highest-index port win a collision
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != c_ZERO_ADDR)) begin
                regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .flush_i      (flush_i),
        .busy_o       (w_busy),
        .busy_count_o (busy_count_o)
    );

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr_i[k*AW +: AW] != c_ZERO_ADDR) begin
                rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
                rd_busy_o[k]              = w_busy[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
                        rd_data_o[k*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
                        rd_busy_o[k]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp : directed and random checks of regfile_mp against an array model
// Rev 1.0
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;
    logic [CW-1:0]       busy_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_reg  [NREG];
    bit              m_busy [NREG];

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .flush_i      (flush),
        .busy_count_o (busy_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] exp_data(input int a);
        logic [31:0] d;
        d = (a == 0) ? 32'h0 : m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && a != 0 && int'(wr_addr[j*AW +: AW]) == a) d = wr_data[j*XLEN +: XLEN];
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input int a);
        logic b;
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && a != 0 && int'(wr_addr[j*AW +: AW]) == a) b = 1'b0;
`endif
        return b;
    endfunction

    // Edge effect from the rules: later ports overwrite, writes free, flush wipes else alloc marks
    task automatic model_update();
        for (int j = 0; j < NWR; j++) begin
            int a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) begin
                m_reg[a]  = wr_data[j*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else if (alloc_en && alloc_addr != 0) begin
            m_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic check_reads(input string tag);
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rd_addr[k*AW +: AW]);
            chk($sformatf("%s_data%0d_a%0d", tag, k, a), rd_data[k*XLEN +: XLEN], exp_data(a));
            chk($sformatf("%s_busy%0d_a%0d", tag, k, a), {31'b0, rd_busy[k]}, {31'b0, exp_busy(a)});
        end
    endtask

    task automatic clear_ctl();
        wr_en    = '0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [31:0] d);
        wr_en[j]              = 1'b1;
        wr_addr[j*AW +: AW]   = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    // Inputs set by caller; checks before the edge, applies the edge, checks after
    task automatic cycle();
        #1;
        check_reads("pre");
        @(posedge clk);
        model_update();
        #1;
        clear_ctl();
        #1;
        check_reads("post");
        chk("busy_count", 32'(busy_count), 32'(m_count()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_addr = '0;
        clear_ctl();
        model_reset();
        #12;
        rst_n = 1'b1;

        // Reset state over every address
        for (int a = 0; a < NREG; a++) begin
            set_rd(0, a);
            set_rd(1, NREG - 1 - a);
            #1;
            check_reads("reset");
        end
        chk("reset_count", 32'(busy_count), 32'd0);

        // Register 0 ignores writes
        set_wr(0, 0, 32'hDEADBEEF);
        set_rd(0, 0);
        cycle();
        chk("r0_after_write", rd_data[31:0], 32'h0);

        // Collision: port 1 wins
        set_wr(0, 5, 32'h1111);
        set_wr(1, 5, 32'h2222);
        set_rd(0, 5);
        cycle();
        chk("collision", rd_data[31:0], 32'h2222);

        // Scoreboard lifecycle on register 7
        set_alloc(7);
        set_rd(1, 7);
        cycle();
        chk("alloc7_busy", {31'b0, rd_busy[1]}, 32'd1);
        chk("alloc7_count", 32'(busy_count), 32'd1);
        set_wr(0, 7, 32'hA5);
        cycle();
        chk("wr7_busy", {31'b0, rd_busy[1]}, 32'd0);
        chk("wr7_count", 32'(busy_count), 32'd0);
        chk("wr7_data", rd_data[63:32], 32'hA5);
        set_alloc(7);
        set_wr(1, 7, 32'h5A);
        cycle();
        chk("alloc_wr7_busy", {31'b0, rd_busy[1]}, 32'd1);
        chk("alloc_wr7_count", 32'(busy_count), 32'd1);
        set_wr(0, 7, 32'h77);
        cycle();

        // Flush beats a same-cycle alloc
        set_alloc(3); cycle();
        set_alloc(4); cycle();
        set_alloc(9); cycle();
        chk("three_busy_count", 32'(busy_count), 32'd3);
        flush = 1'b1;
        set_alloc(12);
        set_rd(0, 12);
        set_rd(1, 9);
        cycle();
        chk("flush_count", 32'(busy_count), 32'd0);
        chk("flush_busy12", {31'b0, rd_busy[0]}, 32'd0);
        chk("flush_busy9", {31'b0, rd_busy[1]}, 32'd0);

        // Same-cycle read of a register being written
        set_alloc(10);
        cycle();
        set_wr(0, 10, 32'hCAFE);
        set_rd(0, 10);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rd_data[31:0], 32'hCAFE);
        chk("bypass_busy", {31'b0, rd_busy[0]}, 32'd0);
`else
        chk("nobypass_data", rd_data[31:0], 32'h0);
        chk("nobypass_busy", {31'b0, rd_busy[0]}, 32'd1);
`endif
        cycle();
        chk("after_write10", rd_data[31:0], 32'hCAFE);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1),
                           $urandom);
            end
            if ($urandom_range(0, 2) == 0) set_alloc($urandom_range(0, NREG - 1));
            flush = ($urandom_range(0, 19) == 0);
            set_rd(0, $urandom_range(0, NREG - 1));
            if ($urandom_range(0, 1) == 1) set_rd(1, int'(wr_addr[AW +: AW]));
            else                           set_rd(1, $urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset between edges with state populated
        set_alloc(5);
        set_wr(0, 6, 32'h1234_5678);
        cycle();
        set_alloc(11);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_count", 32'(busy_count), 32'd0);
        for (int a = 4; a < 13; a++) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            #1;
            chk($sformatf("areset_data_a%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("areset_busy_a%0d", a), {30'b0, rd_busy}, 32'd0);
        end
        model_reset();
        rst_n = 1'b1;
        set_wr(0, 6, 32'h77);
        set_rd(0, 6);
        cycle();
        chk("first_write_after_reset", rd_data[31:0], 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
